// File: rtl/gf_inv_2_unit_pkg.sv
// Shared GF(2^2) definitions for the AES datapath.
// Holds the basis encodings and the mapping of out-of-range basis values.
package gf_inv_2_unit_pkg;

   localparam int BASIS_NORMAL = 0;
   localparam int BASIS_POLY   = 1;

   // Out-of-range basis values fall back to the normal basis.
   function automatic int basis_sel(input int basis);
      return (basis == BASIS_POLY) ? BASIS_POLY : BASIS_NORMAL;
   endfunction

endpackage

// File: rtl/gf_inv_2_unit_core.sv
// Combinational GF(2^2) inverse.
// In this field the inverse is the square, and 0 maps to 0.
module gf_inv_2_core
   import gf_inv_2_unit_pkg::*;
#(
   parameter int BASIS = BASIS_NORMAL
) (
   input  logic [1:0] i_data,
   output logic [1:0] o_data
);

   localparam int BASIS_EFF = basis_sel(BASIS);

   generate
      if (BASIS_EFF == BASIS_POLY) begin : gen_poly
         // With w^2 = w + 1, squaring maps a1*w + a0 to a1*w + (a1 ^ a0).
         assign o_data = {i_data[1], i_data[1] ^ i_data[0]};
      end else begin : gen_normal
         // Squaring in a normal basis is a cyclic shift of the coefficients.
         assign o_data = {i_data[0], i_data[1]};
      end
   endgenerate

endmodule

// File: rtl/gf_inv_2_unit.sv
// GF(2^2) inverse with a valid qualifier.
// Output timing is set by REG_OUT: one registered cycle, or a pure combinational path.
module gf_inv_2_unit
   import gf_inv_2_unit_pkg::*;
#(
   parameter int BASIS   = BASIS_NORMAL,
   parameter int REG_OUT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [1:0] data_in,
   output logic       out_valid,
   output logic [1:0] data_out,
   output logic       zero_flag
);

   logic [1:0] w_inv;
   logic       w_zero;

   gf_inv_2_core #(.BASIS(BASIS)) u_core (
      .i_data (data_in),
      .o_data (w_inv)
   );

   assign w_zero = (data_in == 2'b00);

   generate
      if (REG_OUT != 0) begin : gen_reg
         logic       r_valid;
         logic [1:0] r_data;
         logic       r_zero;

         // Reset wins over in_valid, so a sample taken during reset is dropped.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid <= 1'b0;
               r_data  <= 2'b00;
               r_zero  <= 1'b0;
            end else begin
               r_valid <= in_valid;
               if (in_valid) begin
                  r_data <= w_inv;
                  r_zero <= w_zero;
               end
            end
         end

         assign out_valid = r_valid;
         assign data_out  = r_data;
         assign zero_flag = r_zero;
      end else begin : gen_comb
         assign out_valid = in_valid;
         assign data_out  = w_inv;
         assign zero_flag = w_zero;
      end
   endgenerate

endmodule

// File: tb/tb_gf_inv_2_unit.sv
// Bench for gf_inv_2_unit: registered instances in both bases plus an out-of-range basis,
// scoreboard-checked, and combinational instances swept directly.
module tb_gf_inv_2_unit;

   logic clk;
   logic rst;
   logic in_valid;
   logic [1:0] data_in;
   logic c_valid;
   logic [1:0] c_data;

   logic [2:0]       vld;
   logic [2:0][1:0]  dat;
   logic [2:0]       zf;
   logic       cn_vld, cp_vld, cn_zf, cp_zf;
   logic [1:0] cn_dat, cp_dat;

   int checks = 0;
   int failures = 0;

   // Hand-computed inverse tables.
   logic [1:0] inv_n [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
   logic [1:0] inv_p [4] = '{2'd0, 2'd1, 2'd3, 2'd2};

   logic [2:0] sb_q [3][$];
   logic [2:0] hold [3];
   logic m_vld = 1'b0;
   logic m_rst = 1'b1;
   logic mon_en = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   gf_inv_2_unit #(.BASIS(0), .REG_OUT(1)) u_n (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
      .out_valid(vld[0]), .data_out(dat[0]), .zero_flag(zf[0]));
   gf_inv_2_unit #(.BASIS(1), .REG_OUT(1)) u_p (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
      .out_valid(vld[1]), .data_out(dat[1]), .zero_flag(zf[1]));
   gf_inv_2_unit #(.BASIS(2), .REG_OUT(1)) u_x (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
      .out_valid(vld[2]), .data_out(dat[2]), .zero_flag(zf[2]));
   gf_inv_2_unit #(.BASIS(0), .REG_OUT(0)) u_cn (
      .clk(clk), .rst(rst), .in_valid(c_valid), .data_in(c_data),
      .out_valid(cn_vld), .data_out(cn_dat), .zero_flag(cn_zf));
   gf_inv_2_unit #(.BASIS(1), .REG_OUT(0)) u_cp (
      .clk(clk), .rst(rst), .in_valid(c_valid), .data_in(c_data),
      .out_valid(cp_vld), .data_out(cp_dat), .zero_flag(cp_zf));

   task automatic chk(input string name, input int idx, input logic [3:0] act,
                      input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h want=%0h at %0t", name, idx, act, exp, $time);
      end
   endtask

   // Normal basis {W^2, W}: one is 2'b11.
   function automatic logic [1:0] mul_n(input logic [1:0] a, input logic [1:0] b);
      logic c;
      c = (a[1] & b[0]) ^ (a[0] & b[1]);
      return {(a[0] & b[0]) ^ c, (a[1] & b[1]) ^ c};
   endfunction

   // Polynomial basis {w, 1}, w^2 = w + 1: one is 2'b01.
   function automatic logic [1:0] mul_p(input logic [1:0] a, input logic [1:0] b);
      return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
              (a[1] & b[1]) ^ (a[0] & b[0])};
   endfunction

   task automatic send(input logic r, input logic v, input logic [1:0] d);
      @(posedge clk);
      #1;
      rst = r;
      in_valid = v;
      data_in = d;
      if (v && !r) begin
         sb_q[0].push_back({inv_n[d], d == 2'd0});
         sb_q[1].push_back({inv_p[d], d == 2'd0});
         sb_q[2].push_back({inv_n[d], d == 2'd0});
      end
   endtask

   always @(posedge clk) begin
      m_vld <= in_valid && !rst;
      m_rst <= rst;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            if (m_rst) hold[i] = 3'b000;
            chk("out_valid", i, {3'b000, vld[i]}, {3'b000, m_vld});
            if (vld[i]) begin
               if (sb_q[i].size() == 0) chk("unexpected_out", i, 4'd1, 4'd0);
               else hold[i] = sb_q[i].pop_front();
            end
            chk("data_zero", i, {1'b0, dat[i], zf[i]}, {1'b0, hold[i]});
         end
      end
   end

   initial begin
      logic [1:0] y;
      rst = 1'b1;
      in_valid = 1'b0;
      data_in = 2'd0;
      c_valid = 1'b0;
      c_data = 2'd0;
      for (int i = 0; i < 3; i++) hold[i] = 3'b000;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Samples during reset are dropped.
      send(1'b1, 1'b1, 2'd3);
      send(1'b1, 1'b1, 2'd3);
      send(1'b0, 1'b1, 2'd1);
      send(1'b0, 1'b0, 2'd1);
      // Back-to-back sweep.
      for (int d = 0; d < 4; d++) send(1'b0, 1'b1, 2'(d));
      send(1'b0, 1'b0, 2'd0);
      // Reset clears a latched zero_flag.
      send(1'b0, 1'b1, 2'd0);
      send(1'b1, 1'b0, 2'd0);
      send(1'b0, 1'b0, 2'd2);
      // Hold while in_valid is low.
      send(1'b0, 1'b1, 2'd3);
      for (int k = 0; k < 3; k++) send(1'b0, 1'b0, 2'd1);
      send(1'b0, 1'b1, 2'd2);
      send(1'b0, 1'b1, 2'd0);
      send(1'b0, 1'b0, 2'd3);
      send(1'b0, 1'b0, 2'd3);

      // Combinational instances, stepped at 10 ns.
      for (int d = 0; d < 4; d++) begin
         c_valid = 1'b1;
         c_data = 2'(d);
         #1;
         chk("comb_n_data", d, {2'b00, cn_dat}, {2'b00, inv_n[d]});
         chk("comb_p_data", d, {2'b00, cp_dat}, {2'b00, inv_p[d]});
         chk("comb_zero", d, {3'b000, cn_zf}, {3'b000, d == 0});
         chk("comb_valid", d, {3'b000, cn_vld}, 4'd1);
         #9;
      end
      c_valid = 1'b0;
      #1;
      chk("comb_valid_low", 0, {2'b00, cn_vld, cp_vld}, 4'd0);

      // x * inv(x) is one and inverting twice gives x back.
      for (int x = 1; x < 4; x++) begin
         c_data = 2'(x);
         #1;
         y = cn_dat;
         chk("prod_n", x, {2'b00, mul_n(2'(x), y)}, 4'd3);
         c_data = y;
         #1;
         chk("dbl_inv_n", x, {2'b00, cn_dat}, 4'(x));
         c_data = 2'(x);
         #1;
         y = cp_dat;
         chk("prod_p", x, {2'b00, mul_p(2'(x), y)}, 4'd1);
         c_data = y;
         #1;
         chk("dbl_inv_p", x, {2'b00, cp_dat}, 4'(x));
         #6;
      end

      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk("sb_empty", i, 4'(sb_q[i].size()), 4'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gf_inv_2_unit.md
GF_INV_2_UNIT -- requirements
Module: gf_inv_2

Interface
REQ-001 Parameter BASIS, default 0; selects the GF(2^2) element representation: 0 = normal basis {W^2, W}, 1 = polynomial basis {w, 1} with w^2 = w + 1.
REQ-002 Parameter REG_OUT, default 1; 1 = registered outputs, 0 = combinational outputs.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  qualifies data_in.
REQ-006 data_in  input  2  GF(2^2) operand, bit 1 = high-basis coefficient.
REQ-007 out_valid  output  1  qualifies data_out and zero_flag.
REQ-008 data_out  output  2  multiplicative inverse of the operand, in the same basis as data_in.
REQ-009 zero_flag  output  1  high when the operand was 0 (no true inverse exists).

Function
REQ-010 Inverse in GF(2^2) equals squaring (x^-1 = x^2 for x != 0); 0 SHALL map to 0.
REQ-011 BASIS=0: data_out = {data_in[0], data_in[1]} (bit swap); mapping 0->0, 1->2, 2->1, 3->3.
REQ-012 BASIS=1: data_out = {data_in[1], data_in[1]^data_in[0]}; mapping 0->0, 1->1, 2->3, 3->2.
REQ-013 REG_OUT=1: data_out, zero_flag, out_valid SHALL present the result of the in_valid sample exactly 1 clk cycle later; fixed latency, no backpressure.
REQ-014 REG_OUT=1: data_out and zero_flag SHALL update only on cycles where in_valid=1 and SHALL hold otherwise; out_valid SHALL follow in_valid delayed by one cycle.
REQ-015 REG_OUT=0: outputs SHALL be purely combinational from data_in/in_valid, zero latency; clk and rst SHALL have no effect.
REQ-016 Back-to-back in_valid on consecutive cycles SHALL produce one result per cycle with no loss.
REQ-017 Illegal BASIS values (other than 0/1) SHALL be treated as 0.

Reset
REQ-018 REG_OUT=1: while rst=1 at a rising clk edge, data_out SHALL become 2'b00, zero_flag 0, and out_valid 0.
REQ-019 rst SHALL take precedence over in_valid in the same cycle; a sample presented during reset SHALL be dropped.
REQ-020 The first valid result after reset deassertion SHALL appear 1 cycle after the first in_valid sampled with rst=0.

Structure
REQ-021 BASIS encodings (normal/polynomial constants) SHALL live in the shared AES include/package used by the crypto core.
REQ-022 The arithmetic SHALL be a combinational sub-module gf_inv_2_core (2-bit in, 2-bit out, BASIS parameter); gf_inv_2 adds the valid/register wrapper.
REQ-023 No latches; every combinational path SHALL be fully assigned.

Verification
REQ-024 BASIS=0, REG_OUT=1: drive data_in 0,1,2,3 on consecutive cycles with in_valid=1 -> data_out 0,2,1,3 one cycle later each; zero_flag=1 only for input 0.
REQ-025 BASIS=1, REG_OUT=1: drive 0,1,2,3 -> data_out 0,1,3,2; out_valid high for 4 consecutive cycles.
REQ-026 Reset check: assert rst with in_valid=1, data_in=3 -> data_out=0, out_valid=0, zero_flag=0; release rst, drive in_valid=1, data_in=1 -> next cycle data_out = 2 (BASIS=0), out_valid=1.
REQ-027 Hold check: result 3 latched, then in_valid=0 with data_in=1 for 3 cycles -> data_out stays 3 and out_valid=0.
REQ-028 REG_OUT=0, BASIS=0: sweep data_in 0..3 at 10 ns intervals -> data_out 0,2,1,3 within the same step, independent of clk.
REQ-029 Property, both bases: for every nonzero x, the GF(2^2) product of x and data_out(x) = 1; double inversion returns x.
